// File: rtl/hash_cam_nway.sv
// N-way set-associative hash CAM: XOR-fold hashed buckets, one way examined per
// cycle, serving lookup / insert (with in-place update) / delete one at a time.
module hash_cam_nway #(
  parameter int KEY_WIDTH_IN_OCTETS = 2,
  parameter int VALUE_WIDTH_IN_BITS = 8,
  parameter int INDEX_BITS          = 4,
  parameter int WAYS                = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           op_valid,
  output logic                                           op_ready,
  input  logic [1:0]                                     op_code,
  input  logic [8*KEY_WIDTH_IN_OCTETS-1:0]               key_in,
  input  logic [VALUE_WIDTH_IN_BITS-1:0]                 value_in,
  output logic                                           res_valid,
  output logic                                           res_match,
  output logic                                           res_full,
  output logic [VALUE_WIDTH_IN_BITS-1:0]                 res_value,
  output logic [$clog2((2**INDEX_BITS)*WAYS+1)-1:0]      occupancy
);

  localparam int KW    = 8 * KEY_WIDTH_IN_OCTETS;
  localparam int VW    = VALUE_WIDTH_IN_BITS;
  localparam int NE    = (2**INDEX_BITS) * WAYS;
  localparam int IDX_W = $clog2(NE);
  localparam int OCC_W = $clog2(NE + 1);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [INDEX_BITS-1:0] hash_bucket(input logic [KW-1:0] key);
    logic [7:0] h;
    h = 8'h00;
    for (int i = 0; i < KEY_WIDTH_IN_OCTETS; i++) begin
      h = h ^ key[8*i +: 8];
    end
    return h[INDEX_BITS-1:0];
  endfunction

  state_t                  state_r;
  logic                    op_ready_r;
  logic [1:0]              req_op_r;
  logic [KW-1:0]           req_key_r;
  logic [VW-1:0]           req_value_r;
  logic [INDEX_BITS-1:0]   bucket_r;
  logic [WAY_W-1:0]        way_r;
  logic                    free_found_r;
  logic [WAY_W-1:0]        free_way_r;
  logic                    res_valid_r;
  logic                    res_match_r;
  logic                    res_full_r;
  logic [VW-1:0]           res_value_r;
  logic [OCC_W-1:0]        occ_r;

  logic                    tbl_valid_r [NE];
  logic [KW-1:0]           tbl_key_r   [NE];
  logic [VW-1:0]           tbl_value_r [NE];

  logic [IDX_W-1:0]        cur_idx_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic                    cur_valid_s;
  logic                    cur_hit_s;
  logic                    last_way_s;
  logic                    free_avail_s;

  // Entry under examination this SCAN cycle and the slot an insert miss would fill.
  always_comb begin
    cur_idx_s    = IDX_W'(bucket_r) * IDX_W'(WAYS) + IDX_W'(way_r);
    free_idx_s   = IDX_W'(bucket_r) * IDX_W'(WAYS)
                 + IDX_W'(free_found_r ? free_way_r : way_r);
    cur_valid_s  = tbl_valid_r[cur_idx_s];
    // The reserved op never matches so that it always walks the whole bucket.
    cur_hit_s    = cur_valid_s && (tbl_key_r[cur_idx_s] == req_key_r) && (req_op_r != OP_RSVD);
    last_way_s   = (way_r == WAY_W'(WAYS - 1));
    free_avail_s = free_found_r || !cur_valid_s;
  end

  // Control FSM, table storage and registered results; table writes land on the
  // edge entering DONE so the next request's SCAN already sees them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      op_ready_r   <= 1'b0;
      req_op_r     <= 2'b00;
      req_key_r    <= '0;
      req_value_r  <= '0;
      bucket_r     <= '0;
      way_r        <= '0;
      free_found_r <= 1'b0;
      free_way_r   <= '0;
      res_valid_r  <= 1'b0;
      res_match_r  <= 1'b0;
      res_full_r   <= 1'b0;
      res_value_r  <= '0;
      occ_r        <= '0;
      for (int i = 0; i < NE; i++) begin
        tbl_valid_r[i] <= 1'b0;
        tbl_key_r[i]   <= '0;
        tbl_value_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!op_ready_r) begin
            op_ready_r <= 1'b1;
          end else if (op_valid) begin
            op_ready_r   <= 1'b0;
            req_op_r     <= op_code;
            req_key_r    <= key_in;
            req_value_r  <= value_in;
            bucket_r     <= hash_bucket(key_in);
            way_r        <= '0;
            free_found_r <= 1'b0;
            free_way_r   <= '0;
            state_r      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_hit_s || last_way_s) begin
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
            res_match_r <= cur_hit_s;
            res_full_r  <= 1'b0;
            res_value_r <= '0;
            case (req_op_r)
              OP_LOOKUP: begin
                if (cur_hit_s) res_value_r <= tbl_value_r[cur_idx_s];
              end
              OP_INSERT: begin
                if (cur_hit_s) begin
                  tbl_value_r[cur_idx_s] <= req_value_r;
                end else if (free_avail_s) begin
                  tbl_valid_r[free_idx_s] <= 1'b1;
                  tbl_key_r[free_idx_s]   <= req_key_r;
                  tbl_value_r[free_idx_s] <= req_value_r;
                  occ_r                   <= occ_r + OCC_W'(1);
                end else begin
                  res_full_r <= 1'b1;
                end
              end
              OP_DELETE: begin
                if (cur_hit_s) begin
                  res_value_r            <= tbl_value_r[cur_idx_s];
                  tbl_valid_r[cur_idx_s] <= 1'b0;
                  occ_r                  <= occ_r - OCC_W'(1);
                end
              end
              default: begin
                res_match_r <= 1'b0;
              end
            endcase
          end else begin
            way_r <= way_r + WAY_W'(1);
            if (!cur_valid_s && !free_found_r) begin
              free_found_r <= 1'b1;
              free_way_r   <= way_r;
            end
          end
        end
        ST_DONE: begin
          res_valid_r <= 1'b0;
          op_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          res_valid_r <= 1'b0;
          op_ready_r  <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_ready  = op_ready_r;
  assign res_valid = res_valid_r;
  assign res_match = res_match_r;
  assign res_full  = res_full_r;
  assign res_value = res_value_r;
  assign occupancy = occ_r;

endmodule

// File: doc/hash_cam_nway.md
# hash_cam_nway

N-way set-associative hash CAM: the parametrised successor to the single-way HashCAM. Adds configurable key, value, bucket-count and associativity, an internal XOR-fold hash, in-place value update, delete, and an occupancy counter. It sits between packet-parsing logic and the flow/state tables, serving one lookup, insert or delete at a time through a valid/ready request port and a one-cycle result strobe.

## Interface
- KEY_WIDTH_IN_OCTETS, 2, key width in octets (≥1)
- VALUE_WIDTH_IN_BITS, 8, stored value width
- INDEX_BITS, 4, log2 bucket count (1..8)
- WAYS, 2, entries per bucket (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- op_valid  in  1  request present
- op_ready  out  1  block can accept a request
- op_code  in  2  00 lookup, 01 insert, 10 delete, 11 reserved
- key_in  in  8*KEY_WIDTH_IN_OCTETS  request key
- value_in  in  VALUE_WIDTH_IN_BITS  insert value
- res_valid  out  1  one-cycle result strobe
- res_match  out  1  key was present
- res_full  out  1  insert failed, bucket full
- res_value  out  VALUE_WIDTH_IN_BITS  stored value (lookup/delete hit), else 0
- occupancy  out  clog2(2^INDEX_BITS*WAYS+1)  valid entry count

## Operation
- Storage: 2^INDEX_BITS × WAYS entries of {valid, key, value} in registers.
- Hash: h8 = XOR of all key octets; bucket = h8[INDEX_BITS-1:0].
- FSM IDLE → SCAN → DONE → IDLE. op_ready = 1 only in IDLE; accept on op_valid && op_ready, latching op_code, key, value and bucket.
- SCAN examines one way per cycle, way 0 upward; tracks the lowest-numbered invalid way as the free slot.
- Lookup: first valid key match ends SCAN → DONE with match=1 and its value; otherwise every way is scanned → match=0.
- Insert: a match ends SCAN; DONE overwrites that value (match=1, occupancy unchanged). With no match, all ways are scanned; DONE writes the free slot (match=0, occupancy+1), or if none exists sets full=1 and writes nothing.
- Delete: a match ends SCAN; DONE clears valid, returns the old value, occupancy−1. A miss gives match=0 with no change.
- Reserved op: full scan, then DONE with match=0, full=0, no change.
- Entry write, occupancy update and res_* all occur in the DONE cycle; res_* hold until the next DONE and are qualified only by res_valid.

## Timing
- Request accepted at cycle T. SCAN occupies T+1..T+k: k = w+1 for a hit at way w (lookup/insert/delete), k = WAYS on a miss. DONE/res_valid at T+k+1. op_ready high again at T+k+2.
- Reads in SCAN see the result of all prior DONE writes; back-to-back ops never see stale data.
- Inputs other than op_valid are don't-care outside the accept cycle.
- Reset (any time, including mid-SCAN/DONE): abort the op with no res_valid and no write. All valid bits = 0, state IDLE. op_ready becomes 1 after the first clock edge following reset release. res_valid, res_match, res_full = 0; res_value = 0; occupancy = 0.
- Occupancy never wraps: it saturates logically at the table size because insert into a full bucket is refused.

## Test plan
(Parameters INDEX_BITS=4, WAYS=2, 16-bit keys, 8-bit values.)
- After reset, lookup 0x000A -> res_valid at T+3, match=0, value=0, occupancy=0.
- Insert 0x000A/0x07, then lookup 0x000A -> insert: match=0, full=0, occupancy=1. Lookup hits way 0 with res_valid at T+2, match=1, value=0x07.
- Insert 0x000A/0x08 (update), then lookup -> update: match=1, occupancy stays 1. Lookup returns value 0x08.
- Collisions in bucket 0xA: insert 0x0A00/0x01 (way 1), then 0x1B11/0x02 -> third insert gives full=1, match=0, occupancy=2. Lookup 0x1B11 gives match=0.
- Delete 0x000A -> match=1, value=0x08, occupancy=1. Re-insert 0x1B11/0x02 lands in way 0, full=0. Lookup 0x0A00 hits way 1 with res_valid at T+3.
- Assert reset mid-SCAN of an insert -> no res_valid, occupancy=0. All prior keys miss on lookup after release.
